// File: rtl/ram_copy_if.sv
// Control and RAM-port signals of the ram_copy engine; master is the engine,
// slave is the controller/RAM side that drives start, request fields and read data.
interface ram_copy_if #(
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8
);
  logic                 in_start;
  logic [ADDR_BITS-1:0] in_src_addr;
  logic [ADDR_BITS-1:0] in_dst_addr;
  logic [ADDR_BITS:0]   in_len;
  logic                 out_busy;
  logic                 out_done;
  logic                 out_err;
  logic                 out_read_ena_1;
  logic [ADDR_BITS-1:0] out_addr_1;
  logic [WORD_BITS-1:0] in_data_1;
  logic                 out_write_ena_2;
  logic [ADDR_BITS-1:0] out_addr_2;
  logic [WORD_BITS-1:0] out_data_2;

  modport master (
    input  in_start, in_src_addr, in_dst_addr, in_len, in_data_1,
    output out_busy, out_done, out_err,
    output out_read_ena_1, out_addr_1,
    output out_write_ena_2, out_addr_2, out_data_2
  );

  modport slave (
    output in_start, in_src_addr, in_dst_addr, in_len, in_data_1,
    input  out_busy, out_done, out_err,
    input  out_read_ena_1, out_addr_1,
    input  out_write_ena_2, out_addr_2, out_data_2
  );
endinterface

// File: rtl/ram_copy.sv
// Block copy over a 2-port RAM (port 1 reads, port 2 writes), one word/clock, done at len+2 cycles.
// No backpressure: the RAM always accepts; in_start is ignored (not queued) outside IDLE.
module ram_copy #(
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8,
  parameter int NUM_WORDS = 2**ADDR_BITS
) (
  input logic        in_clk,
  input logic        in_rst,
  ram_copy_if.master bus
);

  localparam int CW = ADDR_BITS + 1;
  localparam int EW = ADDR_BITS + 2;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [CW-1:0]        cnt_t;
  typedef logic [EW-1:0]        ext_t;

  localparam ext_t NW_EXT = ext_t'(NUM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  addr_t  src_q, src_d;
  addr_t  dst_q, dst_d;
  cnt_t   len_q, len_d;
  addr_t  r_q, r_d;
  addr_t  w_q, w_d;
  logic   err_q, err_d;

  ext_t   src_end;
  ext_t   dst_end;
  logic   rd_en;
  logic   wr_en;
  addr_t  rd_addr;
  addr_t  wr_addr;

  // Range check is one bit wider than the largest legal end address so it never wraps.
  assign src_end = ext_t'(bus.in_src_addr) + ext_t'(bus.in_len);
  assign dst_end = ext_t'(bus.in_dst_addr) + ext_t'(bus.in_len);
  assign rd_addr = src_q + r_q;
  assign wr_addr = dst_q + w_q;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      r_q     <= '0;
      w_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      r_q     <= r_d;
      w_q     <= w_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    r_d     = r_q;
    w_d     = w_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_start) begin
          src_d = bus.in_src_addr;
          dst_d = bus.in_dst_addr;
          len_d = bus.in_len;
          r_d   = '0;
          w_d   = '0;
          err_d = 1'b0;
          if (src_end > NW_EXT || dst_end > NW_EXT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (bus.in_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rd_en = 1'b1;
        r_d   = r_q + addr_t'(1);
        // Every RUN cycle reads, so any cycle after the first has a word to write.
        wr_en = (r_q != '0);
        if (wr_en) begin
          w_d = w_q + addr_t'(1);
        end
        if (cnt_t'(r_q) == len_q - cnt_t'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        wr_en   = 1'b1;
        w_d     = w_q + addr_t'(1);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out_busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.out_done        = (state_q == S_DONE);
  assign bus.out_err         = (state_q == S_DONE) && err_q;
  assign bus.out_read_ena_1  = rd_en;
  assign bus.out_addr_1      = rd_en ? rd_addr : '0;
  assign bus.out_write_ena_2 = wr_en;
  assign bus.out_addr_2      = wr_en ? wr_addr : '0;
  assign bus.out_data_2      = wr_en ? bus.in_data_1 : '0;

endmodule

// File: tb/tb_ram_copy.sv
// Bench for ram_copy: behavioural 2-port RAM, table of copy requests checked cycle by cycle.
module tb_ram_copy;
  localparam int AB = 3;
  localparam int WB = 8;
  localparam int NW = 8;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  logic load   = 1'b0;

  ram_copy_if #(.ADDR_BITS(AB), .WORD_BITS(WB)) bus ();

  ram_copy #(.ADDR_BITS(AB), .WORD_BITS(WB), .NUM_WORDS(NW)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  // Registered-read RAM: a read in the same cycle as a write to that word sees old data.
  logic [WB-1:0] mem [NW];
  always @(posedge in_clk) begin
    if (load) begin
      for (int k = 0; k < NW; k++) mem[k] <= WB'(16 + k);
    end else if (bus.out_write_ena_2) begin
      mem[bus.out_addr_2] <= bus.out_data_2;
    end
    if (bus.out_read_ena_1) bus.in_data_1 <= mem[bus.out_addr_1];
  end

  typedef struct {
    int src;
    int dst;
    int len;
    bit exp_acc;   // RAM is touched
    bit exp_err;
    int exp_lat;   // cycle of out_done counted from the start edge
    int restart;   // cycle in which a second start is pulsed (0 = none)
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload();
    @(negedge in_clk);
    load = 1'b1;
    @(negedge in_clk);
    load = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [WB-1:0] m  [NW];
    logic [WB-1:0] wd [NW];
    logic rd, wr;
    preload();
    for (int i = 0; i < NW; i++) m[i] = WB'(16 + i);
    // Forward copy model: read i sees writes 0..i-2 already landed.
    if (v.exp_acc) begin
      for (int i = 0; i < v.len; i++) begin
        if (i >= 2) m[v.dst + i - 2] = wd[i - 2];
        wd[i] = m[v.src + i];
      end
      for (int i = (v.len >= 2 ? v.len - 2 : 0); i < v.len; i++) m[v.dst + i] = wd[i];
    end
    bus.in_start    = 1'b1;
    bus.in_src_addr = AB'(v.src);
    bus.in_dst_addr = AB'(v.dst);
    bus.in_len      = (AB+1)'(v.len);
    for (int k = 1; k <= v.exp_lat + 2; k++) begin
      @(negedge in_clk);
      if (k == v.restart) begin
        bus.in_start    = 1'b1;
        bus.in_src_addr = 3'd3;
        bus.in_dst_addr = 3'd1;
        bus.in_len      = 4'd2;
      end else begin
        bus.in_start = 1'b0;
      end
      rd = v.exp_acc && k <= v.len;
      wr = v.exp_acc && k >= 2 && k <= v.len + 1;
      chk($sformatf("v%0d k%0d read_ena", idx, k), 32'(bus.out_read_ena_1), 32'(rd));
      chk($sformatf("v%0d k%0d addr_1", idx, k), 32'(bus.out_addr_1), rd ? 32'(v.src + k - 1) : 32'd0);
      chk($sformatf("v%0d k%0d write_ena", idx, k), 32'(bus.out_write_ena_2), 32'(wr));
      chk($sformatf("v%0d k%0d addr_2", idx, k), 32'(bus.out_addr_2), wr ? 32'(v.dst + k - 2) : 32'd0);
      if (wr) chk($sformatf("v%0d k%0d data_2", idx, k), 32'(bus.out_data_2), 32'(wd[k - 2]));
      else    chk($sformatf("v%0d k%0d data_2", idx, k), 32'(bus.out_data_2), 32'd0);
      chk($sformatf("v%0d k%0d busy", idx, k), 32'(bus.out_busy), 32'(v.exp_acc && k <= v.len + 1));
      chk($sformatf("v%0d k%0d done", idx, k), 32'(bus.out_done), 32'(k == v.exp_lat));
      if (k == v.exp_lat) chk($sformatf("v%0d err", idx), 32'(bus.out_err), 32'(v.exp_err));
    end
    for (int i = 0; i < NW; i++) chk($sformatf("v%0d mem[%0d]", idx, i), 32'(mem[i]), 32'(m[i]));
    n_vec++;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " busy"}, 32'(bus.out_busy), 32'd0);
    chk({nm, " done"}, 32'(bus.out_done), 32'd0);
    chk({nm, " err"}, 32'(bus.out_err), 32'd0);
    chk({nm, " read_ena"}, 32'(bus.out_read_ena_1), 32'd0);
    chk({nm, " addr_1"}, 32'(bus.out_addr_1), 32'd0);
    chk({nm, " write_ena"}, 32'(bus.out_write_ena_2), 32'd0);
    chk({nm, " addr_2"}, 32'(bus.out_addr_2), 32'd0);
    chk({nm, " data_2"}, 32'(bus.out_data_2), 32'd0);
  endtask

  vec_t tbl [9];

  initial begin
    //           src dst len acc err lat restart
    tbl[0] = '{1, 5, 3, 1'b1, 1'b0, 5,  0};   // basic copy 0x11..0x13 -> 5..7
    tbl[1] = '{0, 0, 8, 1'b1, 1'b0, 10, 0};   // full RAM onto itself
    tbl[2] = '{6, 0, 3, 1'b0, 1'b1, 1,  0};   // src range overflows
    tbl[3] = '{2, 3, 0, 1'b0, 1'b0, 1,  0};   // zero length
    tbl[4] = '{0, 2, 4, 1'b1, 1'b0, 6,  0};   // forward overlap, re-reads written words
    tbl[5] = '{7, 0, 1, 1'b1, 1'b0, 3,  0};   // last word, src+len == NUM_WORDS
    tbl[6] = '{0, 4, 5, 1'b0, 1'b1, 1,  0};   // dst range overflows
    tbl[7] = '{5, 3, 3, 1'b1, 1'b0, 5,  0};   // backward overlap
    tbl[8] = '{0, 4, 4, 1'b1, 1'b0, 6,  2};   // second start during RUN ignored

    bus.in_start    = 1'b0;
    bus.in_src_addr = '0;
    bus.in_dst_addr = '0;
    bus.in_len      = '0;
    in_rst = 1'b1;
    repeat (3) @(negedge in_clk);
    chk_idle("reset");
    n_vec++;
    in_rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // Reset in the cycle of the second write of a len=4 copy.
    preload();
    bus.in_start    = 1'b1;
    bus.in_src_addr = 3'd0;
    bus.in_dst_addr = 3'd4;
    bus.in_len      = 4'd4;
    @(negedge in_clk);                 // cycle T+1
    bus.in_start = 1'b0;
    @(negedge in_clk);                 // T+2: first write
    chk("rst w0 write_ena", 32'(bus.out_write_ena_2), 32'd1);
    @(negedge in_clk);                 // T+3: second write on the bus at the reset edge
    chk("rst w1 write_ena", 32'(bus.out_write_ena_2), 32'd1);
    chk("rst w1 addr_2", 32'(bus.out_addr_2), 32'd5);
    chk("rst w1 data_2", 32'(bus.out_data_2), 32'h11);
    in_rst = 1'b1;
    @(negedge in_clk);                 // T+4
    in_rst = 1'b0;
    chk_idle("post-reset");
    @(negedge in_clk);
    chk_idle("post-reset idle");
    chk("rst mem[3]", 32'(mem[3]), 32'h13);
    chk("rst mem[4]", 32'(mem[4]), 32'h10);
    chk("rst mem[5]", 32'(mem[5]), 32'h11);
    chk("rst mem[6]", 32'(mem[6]), 32'h16);
    chk("rst mem[7]", 32'(mem[7]), 32'h17);
    n_vec++;
    run_vec(9, tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
